// File: rtl/button_event_arbiter_if.sv
// Event handshake between the button arbiter (master) and its consumer (slave).
// The consumer takes one button index per valid/ready handshake.
interface button_event_arbiter_if #(
  parameter int N_BTN = 5
);
  localparam int IDXW = $clog2(N_BTN);

  logic            evt_valid_o;
  logic            evt_ready_i;
  logic [IDXW-1:0] evt_idx_o;

  modport master (output evt_valid_o, output evt_idx_o, input evt_ready_i);
  modport slave  (input evt_valid_o, input evt_idx_o, output evt_ready_i);
endinterface

// File: rtl/button_event_arbiter.sv
// Shared-prescaler debouncer for N_BTN buttons. Confirmed presses become one-shot
// events, and a round-robin arbiter issues them on a single valid/ready port.
module button_event_arbiter #(
  parameter int N_BTN      = 5,
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_BTN-1:0]       btn_i,
  button_event_arbiter_if.master evt,
  output logic [N_BTN-1:0]       held_o,
  output logic [N_BTN-1:0]       overrun_o,
  output logic                   tick_o
);
  localparam int IDXW = $clog2(N_BTN);
  localparam int DIVW = $clog2(SAMPLE_DIV);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIV - 1);
  localparam logic [3:0]      STABLE   = 4'(STABLE_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

  logic [N_BTN-1:0] sync1_r;
  logic [N_BTN-1:0] sync2_r;
  logic [DIVW-1:0]  div_cnt_r;
  logic [DIVW-1:0]  div_nxt_s;
  logic             tick_r;
  btn_state_e       state_r [N_BTN];
  logic [3:0]       cnt_r   [N_BTN];
  logic [N_BTN-1:0] confirm_s;
  logic [N_BTN-1:0] pending_r;
  logic [N_BTN-1:0] pending_nxt_s;
  logic [N_BTN-1:0] overrun_r;
  logic [N_BTN-1:0] overrun_nxt_s;
  logic [N_BTN-1:0] grant_s;
  logic [IDXW-1:0]  last_grant_r;
  logic [IDXW-1:0]  pick_s;
  logic             found_s;
  logic             free_s;
  logic             load_s;
  logic             valid_r;
  logic [IDXW-1:0]  idx_r;

  // Two-flop synchroniser on every raw button level.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= btn_i;
      sync2_r <= sync1_r;
    end
  end

  // Prescaler next count, wrapping after SAMPLE_DIV-1.
  always_comb begin
    if (div_cnt_r == DIV_LAST) begin
      div_nxt_s = '0;
    end else begin
      div_nxt_s = div_cnt_r + DIVW'(1);
    end
  end

  // Prescaler state; the strobe is registered so it is high exactly while count == SAMPLE_DIV-1.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else begin
      div_cnt_r <= div_nxt_s;
      tick_r    <= (div_nxt_s == DIV_LAST);
    end
  end

  // Press confirmation strobe, shared by the FSM and the pending logic.
  always_comb begin
    confirm_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (tick_r && sync2_r[i]) begin
        if (state_r[i] == IDLE) begin
          confirm_s[i] = (STABLE == 4'd1);
        end else if (state_r[i] == PRESS_CHK) begin
          confirm_s[i] = ((cnt_r[i] + 4'd1) == STABLE);
        end else begin
          confirm_s[i] = 1'b0;
        end
      end else begin
        confirm_s[i] = 1'b0;
      end
    end
  end

  // Per-button debounce FSM, advanced only on the sample strobe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= 4'd0;
      end
    end else if (tick_r) begin
      for (int i = 0; i < N_BTN; i++) begin
        case (state_r[i])
          IDLE: begin
            if (sync2_r[i]) begin
              state_r[i] <= (STABLE == 4'd1) ? HELD : PRESS_CHK;
              cnt_r[i]   <= (STABLE == 4'd1) ? 4'd0 : 4'd1;
            end else begin
              cnt_r[i] <= 4'd0;
            end
          end
          PRESS_CHK: begin
            if (!sync2_r[i]) begin
              state_r[i] <= IDLE;
              cnt_r[i]   <= 4'd0;
            end else if ((cnt_r[i] + 4'd1) == STABLE) begin
              state_r[i] <= HELD;
              cnt_r[i]   <= 4'd0;
            end else begin
              cnt_r[i] <= cnt_r[i] + 4'd1;
            end
          end
          HELD: begin
            if (!sync2_r[i]) begin
              state_r[i] <= (STABLE == 4'd1) ? IDLE : REL_CHK;
              cnt_r[i]   <= (STABLE == 4'd1) ? 4'd0 : 4'd1;
            end else begin
              cnt_r[i] <= 4'd0;
            end
          end
          REL_CHK: begin
            // A bounce back to pressed returns to HELD without a new event.
            if (sync2_r[i]) begin
              state_r[i] <= HELD;
              cnt_r[i]   <= 4'd0;
            end else if ((cnt_r[i] + 4'd1) == STABLE) begin
              state_r[i] <= IDLE;
              cnt_r[i]   <= 4'd0;
            end else begin
              cnt_r[i] <= cnt_r[i] + 4'd1;
            end
          end
          default: begin
            state_r[i] <= IDLE;
            cnt_r[i]   <= 4'd0;
          end
        endcase
      end
    end
  end

  // Round-robin pick starting after last_grant, plus pending/overrun next state.
  always_comb begin
    int unsigned scan_v;
    scan_v  = 0;
    pick_s  = '0;
    found_s = 1'b0;
    for (int k = 1; k <= N_BTN; k++) begin
      scan_v = (int'(last_grant_r) + k) % N_BTN;
      if (!found_s && pending_r[scan_v]) begin
        found_s = 1'b1;
        pick_s  = IDXW'(scan_v);
      end else begin
        found_s = found_s;
      end
    end
    free_s = !valid_r || evt.evt_ready_i;
    load_s = free_s && found_s;
    for (int i = 0; i < N_BTN; i++) begin
      grant_s[i]       = load_s && (pick_s == IDXW'(i));
      // A confirm in the same cycle its old event is loaded re-arms pending instead of overrunning.
      pending_nxt_s[i] = (pending_r[i] && !grant_s[i]) || confirm_s[i];
      overrun_nxt_s[i] = overrun_r[i] || (confirm_s[i] && pending_r[i] && !grant_s[i]);
    end
  end

  // Pending/overrun flags and the event output register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_r    <= '0;
      overrun_r    <= '0;
      valid_r      <= 1'b0;
      idx_r        <= '0;
      last_grant_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
      overrun_r <= overrun_nxt_s;
      if (free_s) begin
        valid_r <= found_s;
        if (found_s) begin
          idx_r        <= pick_s;
          last_grant_r <= pick_s;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      held_o[i] = (state_r[i] == HELD) || (state_r[i] == REL_CHK);
    end
  end

  assign overrun_o       = overrun_r;
  assign tick_o          = tick_r;
  assign evt.evt_valid_o = valid_r;
  assign evt.evt_idx_o   = idx_r;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with SAMPLE_DIV=4, STABLE_CNT=3, N_BTN=5.
module tb_button_event_arbiter;
  localparam int N_BTN      = 5;
  localparam int SAMPLE_DIV = 4;
  localparam int STABLE_CNT = 3;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] held_o;
  logic [N_BTN-1:0] overrun_o;
  logic             tick_o;

  int checks   = 0;
  int failures = 0;

  button_event_arbiter_if #(.N_BTN(N_BTN)) bus ();

  button_event_arbiter #(
    .N_BTN(N_BTN), .SAMPLE_DIV(SAMPLE_DIV), .STABLE_CNT(STABLE_CNT)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_i), .evt(bus),
    .held_o(held_o), .overrun_o(overrun_o), .tick_o(tick_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Reset for two cycles; release together with the given button levels on a falling edge.
  task automatic apply_reset(input logic [N_BTN-1:0] btn_after);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    btn_i   = btn_after;
    reset_i = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit got);
    got = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk_i);
      if (bus.evt_valid_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    btn_i = '0;
    bus.evt_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (bus.evt_valid_o !== 1'b0 || bus.evt_idx_o !== 3'd0 || held_o !== 5'd0 ||
        overrun_o !== 5'd0 || tick_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b idx=%0d held=%b ovr=%b tick=%b, required all 0",
               bus.evt_valid_o, bus.evt_idx_o, held_o, overrun_o, tick_o);
    end
    reset_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_i);
      checks++;
      if (tick_o !== ((c % 4) == 3)) begin
        failures++;
        $display("FAIL tick_pattern: cycle %0d tick=%b, required %b", c, tick_o, ((c % 4) == 3));
      end
    end
  endtask

  task automatic test_single_press();
    int first_c = 0;
    int nvalid = 0;
    logic [2:0] idx_seen = 3'd7;
    logic held11 = 1'b1;
    logic held12 = 1'b0;
    bus.evt_ready_i = 1'b1;
    apply_reset(5'b00100);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk_i);
      if (c == 11) held11 = held_o[2];
      if (c == 12) held12 = held_o[2];
      if (bus.evt_valid_o) begin
        nvalid++;
        if (first_c == 0) begin
          first_c = c;
          idx_seen = bus.evt_idx_o;
        end
      end
    end
    checks++;
    if (first_c != 13) begin
      failures++;
      $display("FAIL press_latency: first valid at cycle %0d, required 13", first_c);
    end
    checks++;
    if (idx_seen !== 3'd2) begin
      failures++;
      $display("FAIL press_idx: idx=%0d, required 2", idx_seen);
    end
    checks++;
    if (nvalid != 1) begin
      failures++;
      $display("FAIL press_once: %0d valid cycles while held, required 1", nvalid);
    end
    checks++;
    if (held11 !== 1'b0 || held12 !== 1'b1) begin
      failures++;
      $display("FAIL held_timing: held@11=%b held@12=%b, required 0 then 1", held11, held12);
    end
    checks++;
    if (held_o !== 5'b00100) begin
      failures++;
      $display("FAIL held_level: held=%b, required 00100", held_o);
    end
    btn_i = '0;
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (bus.evt_valid_o) nvalid++;
    end
    checks++;
    if (held_o !== 5'b00000 || nvalid != 0) begin
      failures++;
      $display("FAIL release: held=%b events=%0d, required 00000 and 0", held_o, nvalid);
    end
  endtask

  task automatic test_bounce();
    int nvalid = 0;
    logic held_seen = 1'b0;
    bus.evt_ready_i = 1'b1;
    btn_i = '0;
    for (int r = 0; r < 3; r++) begin
      btn_i[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_i);
        if (bus.evt_valid_o) nvalid++;
        if (held_o[1]) held_seen = 1'b1;
      end
      btn_i[1] = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk_i);
        if (bus.evt_valid_o) nvalid++;
        if (held_o[1]) held_seen = 1'b1;
      end
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i);
      if (bus.evt_valid_o) nvalid++;
      if (held_o[1]) held_seen = 1'b1;
    end
    checks++;
    if (nvalid != 0 || held_seen !== 1'b0) begin
      failures++;
      $display("FAIL bounce: events=%0d held_seen=%b, required 0 and 0", nvalid, held_seen);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    bus.evt_ready_i = 1'b1;
    apply_reset(5'b00001);
    wait_valid(40, got);
    checks++;
    if (!got || bus.evt_idx_o !== 3'd0) begin
      failures++;
      $display("FAIL rr_setup: got=%b idx=%0d, required event idx 0", got, bus.evt_idx_o);
    end
    btn_i = '0;
    wait_cycles(40);
    btn_i = 5'b11001;
    wait_valid(40, got);
    checks++;
    if (!got || bus.evt_idx_o !== 3'd3) begin
      failures++;
      $display("FAIL rr_first: got=%b idx=%0d, required idx 3", got, bus.evt_idx_o);
    end
    @(negedge clk_i);
    checks++;
    if (bus.evt_valid_o !== 1'b1 || bus.evt_idx_o !== 3'd4) begin
      failures++;
      $display("FAIL rr_second: valid=%b idx=%0d, required 1 and 4", bus.evt_valid_o, bus.evt_idx_o);
    end
    @(negedge clk_i);
    checks++;
    if (bus.evt_valid_o !== 1'b1 || bus.evt_idx_o !== 3'd0) begin
      failures++;
      $display("FAIL rr_third: valid=%b idx=%0d, required 1 and 0", bus.evt_valid_o, bus.evt_idx_o);
    end
    @(negedge clk_i);
    checks++;
    if (bus.evt_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain: valid=%b, required 0", bus.evt_valid_o);
    end
    btn_i = '0;
    wait_cycles(40);
  endtask

  task automatic test_stall();
    bit got;
    bit stable = 1'b1;
    bus.evt_ready_i = 1'b0;
    apply_reset(5'b00010);
    wait_valid(40, got);
    checks++;
    if (!got || bus.evt_idx_o !== 3'd1) begin
      failures++;
      $display("FAIL stall_setup: got=%b idx=%0d, required event idx 1", got, bus.evt_idx_o);
    end
    btn_i = 5'b10010;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_i);
      if (!(bus.evt_valid_o === 1'b1 && bus.evt_idx_o === 3'd1)) stable = 1'b0;
    end
    checks++;
    if (!stable || held_o !== 5'b10010) begin
      failures++;
      $display("FAIL stall_hold: stable=%b held=%b, required 1 and 10010", stable, held_o);
    end
    bus.evt_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (bus.evt_valid_o !== 1'b1 || bus.evt_idx_o !== 3'd4) begin
      failures++;
      $display("FAIL stall_next: valid=%b idx=%0d, required 1 and 4", bus.evt_valid_o, bus.evt_idx_o);
    end
    @(negedge clk_i);
    checks++;
    if (bus.evt_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain: valid=%b, required 0", bus.evt_valid_o);
    end
    btn_i = '0;
    wait_cycles(40);
  endtask

  task automatic test_overrun();
    int n1 = 0;
    int n2 = 0;
    int nother = 0;
    bus.evt_ready_i = 1'b0;
    apply_reset(5'b00010);
    wait_cycles(30);
    checks++;
    if (bus.evt_valid_o !== 1'b1 || bus.evt_idx_o !== 3'd1) begin
      failures++;
      $display("FAIL ovr_setup: valid=%b idx=%0d, required 1 and 1", bus.evt_valid_o, bus.evt_idx_o);
    end
    btn_i[2] = 1'b1;
    wait_cycles(30);
    btn_i[2] = 1'b0;
    wait_cycles(30);
    checks++;
    if (overrun_o !== 5'b00000 || held_o[2] !== 1'b0) begin
      failures++;
      $display("FAIL ovr_premature: ovr=%b held2=%b, required 00000 and 0", overrun_o, held_o[2]);
    end
    btn_i[2] = 1'b1;
    wait_cycles(30);
    checks++;
    if (overrun_o !== 5'b00100) begin
      failures++;
      $display("FAIL ovr_set: ovr=%b, required 00100", overrun_o);
    end
    bus.evt_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.evt_valid_o) begin
        if (bus.evt_idx_o == 3'd1) n1++;
        else if (bus.evt_idx_o == 3'd2) n2++;
        else nother++;
      end
      @(negedge clk_i);
    end
    checks++;
    if (n1 != 1 || n2 != 1 || nother != 0) begin
      failures++;
      $display("FAIL ovr_delivery: idx1=%0d idx2=%0d other=%0d, required 1 1 0", n1, n2, nother);
    end
    checks++;
    if (overrun_o !== 5'b00100) begin
      failures++;
      $display("FAIL ovr_sticky: ovr=%b, required 00100", overrun_o);
    end
    btn_i = '0;
    wait_cycles(40);
  endtask

  task automatic test_reset_mid();
    bit got;
    int first_c = 0;
    logic [2:0] idx_first = 3'd7;
    logic [N_BTN-1:0] held11 = '1;
    logic [N_BTN-1:0] held12 = '0;
    bus.evt_ready_i = 1'b0;
    apply_reset(5'b01000);
    wait_valid(40, got);
    checks++;
    if (!got || bus.evt_idx_o !== 3'd3) begin
      failures++;
      $display("FAIL mid_setup: got=%b idx=%0d, required event idx 3", got, bus.evt_idx_o);
    end
    btn_i = 5'b01001;
    wait_cycles(6);
    reset_i = 1'b1;
    #1;
    checks++;
    if (bus.evt_valid_o !== 1'b0 || bus.evt_idx_o !== 3'd0 || held_o !== 5'd0 ||
        overrun_o !== 5'd0 || tick_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b idx=%0d held=%b ovr=%b tick=%b, required all 0",
               bus.evt_valid_o, bus.evt_idx_o, held_o, overrun_o, tick_o);
    end
    repeat (2) @(negedge clk_i);
    bus.evt_ready_i = 1'b1;
    reset_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      if (c == 11) held11 = held_o;
      if (c == 12) held12 = held_o;
      if (bus.evt_valid_o && first_c == 0) begin
        first_c = c;
        idx_first = bus.evt_idx_o;
      end
    end
    checks++;
    if (held11 !== 5'b00000 || held12 !== 5'b01001) begin
      failures++;
      $display("FAIL mid_redebounce: held@11=%b held@12=%b, required 00000 then 01001", held11, held12);
    end
    checks++;
    if (first_c != 13 || idx_first !== 3'd3) begin
      failures++;
      $display("FAIL mid_first_event: cycle=%0d idx=%0d, required 13 and 3", first_c, idx_first);
    end
    btn_i = '0;
    wait_cycles(40);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_back_to_back();
    test_stall();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
